gate_checker: RTL and testbench

Synthesizable self-checking exerciser for 2-input combinational gates: on `start` it drives every input combination onto a gate under test, samples the gate output after a programmable settle time and compares it with an expected truth table. It reports per-vector failures, an error count and an overall pass flag. It sits beside any 2-input gate in the design (e.g. `and2gate`) so exhaustive gate checks run in hardware rather than only in a bench.

---
 rtl/gate_checker_if.sv | 24 ++
 rtl/gate_checker.sv | 125 ++++++++++++
 tb/tb_gate_checker.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/gate_checker_if.sv
// Control, status and gate-under-test signals of gate_checker.
// master = the checker itself, slave = whoever drives start/f_in and reads the results.
interface gate_checker_if;
  logic       start;
  logic [3:0] truth_table;
  logic       f_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [2:0] err_count;

  modport master (
    input  start, truth_table, f_in,
    output a_out, b_out, busy, done, pass, fail_mask, err_count
  );

  modport slave (
    output start, truth_table, f_in,
    input  a_out, b_out, busy, done, pass, fail_mask, err_count
  );
endinterface

// File: rtl/gate_checker.sv
// Exhaustive 2-input gate exerciser: walks {A,B} = 0..3, holds each for SETTLE_CYCLES+1 cycles,
// samples f_in on the last edge of each vector; done pulses 4*(SETTLE_CYCLES+1) edges after start, start ignored while running.
module gate_checker #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  gate_checker_if.master bus
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] tt_q, tt_d;
  logic       a_q, a_d, b_q, b_d;
  logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [3:0] fm_q, fm_d;
  logic [2:0] ec_q, ec_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 8'd0;
      tt_q    <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fm_q    <= 4'd0;
      ec_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fm_q    <= fm_d;
      ec_q    <= ec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fm_d    = fm_q;
    ec_d    = ec_q;

    case (state_q)
      IDLE: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = 1'b0;
        if (bus.start) begin
          state_d = APPLY;
          idx_d   = 2'd0;
          cnt_d   = 8'd0;
          tt_d    = bus.truth_table;
          fm_d    = 4'd0;
          ec_d    = 3'd0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      APPLY: begin
        if (cnt_q == SETTLE) begin
          cnt_d = 8'd0;
          if (bus.f_in != tt_q[idx_q]) begin
            fm_d[idx_q] = 1'b1;
            ec_d        = ec_q + 3'd1;
          end
          if (idx_q == 2'd3) begin
            // pass is resolved here so it is already valid during the done pulse
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (fm_d == 4'd0);
            a_d     = 1'b0;
            b_d     = 1'b0;
          end else begin
            idx_d      = idx_q + 2'd1;
            {a_d, b_d} = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
        a_d     = 1'b0;
        b_d     = 1'b0;
        busy_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = fm_q;
  assign bus.err_count = ec_q;

endmodule

// File: tb/tb_gate_checker.sv
// Randomized bench for gate_checker: two instances (settle 1 and settle 0) share stimulus and a gate model;
// a cycle-level reference predicts drive sequence, done timing and results, and a negedge monitor compares.
module tb_gate_checker;

  typedef struct packed {
    logic       pass;
    logic [3:0] mask;
    logic [2:0] err;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start = 2'b00;
  logic [3:0] tt = 4'd0;
  logic [3:0] gtt = 4'd0;

  always #5 clk = ~clk;

  gate_checker_if bus0();
  gate_checker_if bus1();

  assign bus0.start       = start[0];
  assign bus0.truth_table = tt;
  assign bus0.f_in        = gtt[{bus0.a_out, bus0.b_out}];
  assign bus1.start       = start[1];
  assign bus1.truth_table = tt;
  assign bus1.f_in        = gtt[{bus1.a_out, bus1.b_out}];

  gate_checker #(.SETTLE_CYCLES(1)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  gate_checker #(.SETTLE_CYCLES(0)) u_s0 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   acc[2];
  int   next_ok[2];
  bit   active[2];
  res_t last[2];
  res_t q0[$];
  res_t q1[$];

  // cycles each vector is held: settle + 1
  function automatic int hold(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic res_t expect_res(input logic [3:0] table_exp, input logic [3:0] gate);
    res_t r;
    r.mask = table_exp ^ gate;
    r.err  = 3'($countones(r.mask));
    r.pass = (r.mask == 4'd0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: a start is accepted when the instance is idle; a run occupies 4*hold+2 edges.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (start[d] && cyc >= next_ok[d]) begin
          acc[d]     = cyc;
          next_ok[d] = cyc + 4 * hold(d) + 2;
          active[d]  = 1'b1;
          if (d == 0) q0.push_back(expect_res(tt, gtt));
          else        q1.push_back(expect_res(tt, gtt));
        end
      end
    end
  end

  task automatic mon(input int d, input logic busy, input logic done, input logic a, input logic b,
                     input logic pass, input logic [3:0] mask, input logic [2:0] err);
    int    h;
    int    k;
    res_t  got;
    res_t  r;
    string tag;
    h   = hold(d);
    got = {pass, mask, err};
    tag = (d == 0) ? "s1" : "s0";
    if (active[d]) begin
      k = cyc - acc[d];
      if (k < 4 * h) begin
        chk({tag, " drive"}, 32'({busy, done, a, b}), 32'({2'b10, 2'(k / h)}));
        if (k == 0) chk({tag, " cleared"}, 32'(got), 32'd0);
      end else begin
        chk({tag, " done"}, 32'({busy, done, a, b}), 32'({4'b0100}));
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          chk({tag, " scoreboard"}, 32'd0, 32'd1);
        end else begin
          r = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk({tag, " result"}, 32'(got), 32'(r));
          last[d] = r;
        end
        active[d] = 1'b0;
      end
    end else begin
      chk({tag, " idle"}, 32'({busy, done, a, b, got}), 32'({4'b0000, last[d]}));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, bus0.busy, bus0.done, bus0.a_out, bus0.b_out, bus0.pass, bus0.fail_mask, bus0.err_count);
      mon(1, bus1.busy, bus1.done, bus1.a_out, bus1.b_out, bus1.pass, bus1.fail_mask, bus1.err_count);
    end
  end

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      next_ok[d] = 0;
      active[d]  = 1'b0;
      last[d]    = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic chk_zero(input string name);
    chk({name, " s1"}, 32'({bus0.a_out, bus0.b_out, bus0.busy, bus0.done, bus0.pass, bus0.fail_mask, bus0.err_count}), 32'd0);
    chk({name, " s0"}, 32'({bus1.a_out, bus1.b_out, bus1.busy, bus1.done, bus1.pass, bus1.fail_mask, bus1.err_count}), 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((active[0] || active[1]) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("run completes", 32'({active[0], active[1]}), 32'd0);
  endtask

  task automatic run(input logic [3:0] t, input logic [3:0] g);
    @(negedge clk);
    tt    = t;
    gtt   = g;
    start = 2'b11;
    @(negedge clk);
    start = 2'b00;
    wait_idle();
  endtask

  initial begin
    clear_model();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    run(4'b1000, 4'b1000);   // AND gate
    run(4'b1000, 4'b0000);   // output stuck at 0
    run(4'b1000, 4'b0111);   // NAND against AND table
    run(4'b0110, 4'b1110);   // OR against XOR table

    // restart attempt mid-run must be ignored
    @(negedge clk);
    tt = 4'b1000; gtt = 4'b1000; start = 2'b11;
    @(negedge clk); start = 2'b00;
    repeat (2) @(negedge clk);
    start = 2'b11;
    @(negedge clk); start = 2'b00;
    wait_idle();

    // start held high: back-to-back runs, failing results cleared on each acceptance
    @(negedge clk);
    tt = 4'b1000; gtt = 4'b0111; start = 2'b11;
    repeat (27) @(negedge clk);
    start = 2'b00;
    wait_idle();

    // reset while vector 2 is applied on the settle-1 instance
    @(negedge clk);
    tt = 4'b1000; gtt = 4'b1000; start = 2'b11;
    @(negedge clk); start = 2'b00;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    clear_model();
    #1 chk_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run(4'b1000, 4'b1000);

    repeat (40) begin
      @(negedge clk);
      tt  = 4'($urandom);
      gtt = ($urandom_range(0, 1) == 1) ? tt : 4'($urandom);
      repeat ($urandom_range(1, 4)) begin
        start = 2'($urandom);
        @(negedge clk);
      end
      start = 2'b00;
      @(negedge clk);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
